// File: rtl/sdspi_arb_pkg.sv
// Shared types and helpers for the sdspihost arbiter.
package sdspi_arb_pkg;

  typedef enum logic [2:0] {
    StInit    = 3'd0,
    StIdle    = 3'd1,
    StGrant   = 3'd2,
    StDrain   = 3'd3,
    StRecover = 3'd4
  } state_t;

  localparam int unsigned INIT_SETTLE = 2;

  // First set bit strictly after ptr, wrapping within n requesters (n <= 4).
  function automatic int unsigned rr_pick(input logic [3:0] req, input int unsigned ptr,
                                          input int unsigned n);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int unsigned i = 4; i >= 1; i--) begin
      if (i <= n) begin
        idx = 2'((ptr + i) % n);
        if (req[idx]) rr_pick = 32'(idx);
      end
    end
  endfunction

endpackage

// File: rtl/sdspi_arbiter_if.sv
// Host-side bus between the arbiter (master) and the sdspihost controller (slave).
interface sdspi_arbiter_if;
  logic        host_rst;
  logic        host_r_block;
  logic        host_r_multi_block;
  logic        host_r_byte;
  logic        host_w_block;
  logic        host_w_byte;
  logic [31:0] host_block_addr;
  logic [7:0]  host_data_in;
  logic        host_busy;
  logic        host_err;
  logic        host_crc_err;
  logic [7:0]  host_data_out;

  modport master (
    output host_rst, host_r_block, host_r_multi_block, host_r_byte, host_w_block, host_w_byte,
    output host_block_addr, host_data_in,
    input  host_busy, host_err, host_crc_err, host_data_out
  );

  modport slave (
    input  host_rst, host_r_block, host_r_multi_block, host_r_byte, host_w_block, host_w_byte,
    input  host_block_addr, host_data_in,
    output host_busy, host_err, host_crc_err, host_data_out
  );
endinterface

// File: rtl/sdspi_arbiter_rr_arbiter.sv
// Round-robin picker: combinational one-hot winner plus a registered last-winner pointer.
module rr_arbiter
  import sdspi_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             take_i,
  output logic [N_REQ-1:0] pick_o
);

  logic [1:0] ptr_q, ptr_d, win;

  always_comb begin
    win    = 2'(rr_pick(4'(req_i), 32'(ptr_q), N_REQ));
    pick_o = {{(N_REQ-1){1'b0}}, 1'b1} << win;
    ptr_d  = take_i ? win : ptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= 2'(N_REQ - 1);
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sdspi_arbiter.sv
// Shares one sdspihost controller between N_REQ requesters: bring-up, round-robin grant,
// datapath mux and a busy watchdog that resets the host when a transaction hangs.
module sdspi_arbiter
  import sdspi_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned TIMEOUT_W  = 24,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  output logic [N_REQ-1:0]     gnt,
  input  logic [N_REQ-1:0]     req_r_block,
  input  logic [N_REQ-1:0]     req_r_multi_block,
  input  logic [N_REQ-1:0]     req_r_byte,
  input  logic [N_REQ-1:0]     req_w_block,
  input  logic [N_REQ-1:0]     req_w_byte,
  input  logic [32*N_REQ-1:0]  req_block_addr,
  input  logic [8*N_REQ-1:0]   req_data_in,
  output logic [N_REQ-1:0]     req_busy,
  output logic [7:0]           req_data_out,
  output logic [N_REQ-1:0]     req_err,
  output logic [N_REQ-1:0]     req_crc_err,
  sdspi_arbiter_if.master      host,
  output logic                 init_err,
  output logic                 timeout,
  output logic [2:0]           state_dbg
);

  state_t               state_q, state_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d, pick;
  logic                 host_rst_q, host_rst_d;
  logic                 init_err_q, init_err_d, timeout_q, timeout_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 take, wd_fire, settled;
  logic [31:0]          addr_mux;
  logic [7:0]           din_mux;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk_i  (clk),
    .rst_i  (rst),
    .req_i  (req),
    .take_i (take),
    .pick_o (pick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StInit;
      gnt_q      <= '0;
      host_rst_q <= 1'b1;
      init_err_q <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      host_rst_q <= host_rst_d;
      init_err_q <= init_err_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
      wd_q       <= wd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    init_err_d = init_err_q;
    timeout_d  = timeout_q;
    cnt_d      = cnt_q;
    wd_d       = '0;
    take       = 1'b0;
    wd_fire    = 1'b0;
    // cnt_q doubles as the post-reset settle counter (INIT) and the reset-hold counter (RECOVER).
    settled    = !host_rst_q && (cnt_q == 8'(INIT_SETTLE));

    if ((state_q == StGrant || state_q == StDrain) && host.host_busy) begin
      wd_d    = wd_q + TIMEOUT_W'(1);
      wd_fire = &wd_d;
    end

    unique case (state_q)
      StInit: begin
        if (host_rst_q)   cnt_d = '0;
        else if (!settled) cnt_d = cnt_q + 8'd1;
        else if (!host.host_busy || host.host_err) begin
          state_d = StIdle;
          cnt_d   = '0;
          if (host.host_err) init_err_d = 1'b1;
        end
      end
      StIdle: begin
        if (|req) begin
          take    = 1'b1;
          gnt_d   = pick;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (!(|(req & gnt_q))) begin
          gnt_d   = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!host.host_busy) state_d = StIdle;
      end
      StRecover: begin
        if (cnt_q == 8'(RST_CYCLES - 1)) begin
          state_d = StInit;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StInit;
    endcase

    if (wd_fire) begin
      timeout_d = 1'b1;
      gnt_d     = '0;
      state_d   = StRecover;
      cnt_d     = '0;
      wd_d      = '0;
    end

    host_rst_d = (state_d == StRecover);
  end

  // gnt_q is non-zero only in GRANT, so it alone gates the datapath.
  always_comb begin
    addr_mux = '0;
    din_mux  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_q[i]) begin
        addr_mux = addr_mux | req_block_addr[32*i +: 32];
        din_mux  = din_mux | req_data_in[8*i +: 8];
      end
    end
    req_busy    = ~gnt_q | {N_REQ{host.host_busy}};
    req_err     = gnt_q & {N_REQ{host.host_err}};
    req_crc_err = gnt_q & {N_REQ{host.host_crc_err}};
  end

  assign host.host_rst           = host_rst_q;
  assign host.host_r_block       = |(gnt_q & req_r_block);
  assign host.host_r_multi_block = |(gnt_q & req_r_multi_block);
  assign host.host_r_byte        = |(gnt_q & req_r_byte);
  assign host.host_w_block       = |(gnt_q & req_w_block);
  assign host.host_w_byte        = |(gnt_q & req_w_byte);
  assign host.host_block_addr    = addr_mux;
  assign host.host_data_in       = din_mux;
  assign req_data_out            = host.host_data_out;
  assign gnt                     = gnt_q;
  assign init_err                = init_err_q;
  assign timeout                 = timeout_q;
  assign state_dbg               = state_q;

endmodule

// File: doc/sdspi_arbiter.md
Name: sdspi_arbiter

Overview:
Shares one sdspihost SD/SPI controller between N_REQ requesters, for example the autotest FSM and a result logger that writes measurement records to the card.
It sequences host bring-up after reset and grants the host to one requester at a time using round-robin priority.
It muxes the command, address and data paths to the host and returns host status only to the granted requester.
A busy watchdog resets and re-initialises the host if a transaction hangs.

Parameters:
N_REQ, 2, number of requesters (2..4).
TIMEOUT_W, 24, watchdog counter width; the timeout fires after 2^TIMEOUT_W-1 consecutive busy cycles.
RST_CYCLES, 4, number of cycles host_rst is held during recovery.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  synchronous, active-high reset.
req  in  N_REQ  per-requester access request; held high for the whole transaction.
gnt  out  N_REQ  one-hot grant; registered.
req_r_block, req_r_multi_block, req_r_byte, req_w_block, req_w_byte  in  N_REQ each  per-requester command strobes.
req_block_addr  in  32*N_REQ  packed block addresses; slice i belongs to requester i.
req_data_in  in  8*N_REQ  packed write bytes.
req_busy  out  N_REQ  host busy as seen by each requester; forced to 1 when that requester is not granted.
req_data_out  out  8  host read byte, broadcast to all requesters.
req_err, req_crc_err  out  N_REQ  host err and crc_err, routed to the granted requester only.
host_rst  out  1  sdspihost reset.
host_r_block, host_r_multi_block, host_r_byte, host_w_block, host_w_byte  out  1 each  host command strobes.
host_block_addr  out  32  host block address.
host_data_in  out  8  host write byte.
host_busy, host_err, host_crc_err  in  1 each  host status.
host_data_out  in  8  host read byte.
init_err  out  1  sticky; host err was seen during INIT.
timeout  out  1  sticky; the watchdog fired.
state_dbg  out  3  current FSM state encoding.

Behaviour:
- Reset values:
  - gnt=0, host_rst=1, all host strobes 0, host_block_addr=0, host_data_in=0.
  - req_busy all 1, req_err=0, req_crc_err=0, init_err=0, timeout=0.
  - state=INIT, round-robin pointer=N_REQ-1, so requester 0 wins first.
- host_rst is registered. It is deasserted on the first clock after rst falls.
- INIT state:
  - Entered after reset and after recovery.
  - Waits for host_busy=0 while host_rst=0, then goes to IDLE on the next edge.
  - If host_err=1 in INIT, set init_err and still go to IDLE.
  - A wait counter of 2 cycles after host_rst deassert masks a stale busy=0.
- IDLE state:
  - All host strobes are forced to 0.
  - If any req bit is set, choose the first set bit searching upward from pointer+1 with wrap-around.
  - Register gnt, update pointer to the winner, go to GRANT.
  - Latency from req rising to gnt high is 1 cycle.
- GRANT state:
  - The host strobes, addr and data_in take the winner's inputs combinationally.
  - Non-granted strobes are ignored.
  - The winner's req_busy, req_err and req_crc_err follow the host.
  - When req[winner] falls: clear gnt on that edge, go to DRAIN.
- DRAIN state:
  - Strobes forced to 0.
  - Wait for host_busy=0, then go to IDLE.
  - A new grant needs at least 1 IDLE cycle, so the back-to-back handover gap is 2 cycles.
- Requests raised while another requester is granted wait; there is no pre-emption.
- Watchdog:
  - Counts while in GRANT or DRAIN and host_busy=1; clears when host_busy=0.
  - On reaching all-ones: set timeout, clear gnt, go to RECOVER.
- RECOVER state:
  - host_rst=1 for RST_CYCLES cycles, strobes 0, then go to INIT.
  - The requester whose grant was revoked must drop req. A req still high after INIT is re-arbitrated normally.
- Reset asserted mid-operation overrides every state on the next edge. The pointer also resets.
- A strobe asserted in the same cycle as gnt rising is ignored. Requesters must wait until they see gnt=1.

Decomposition:
- Package sdspi_arb_pkg holds:
  - the state_t enum {INIT, IDLE, GRANT, DRAIN, RECOVER}, with 3-bit encoding exported on state_dbg;
  - the INIT_SETTLE=2 constant;
  - an rr_pick function implementing the wrap-around priority search.
- Sub-module rr_arbiter (combinational pick plus registered pointer) is natural and reusable.
- The datapath mux lives in the top level.

Test Plan:
- Bring-up: rst for 3 cycles, host busy for 100 cycles then 0 → host_rst low 1 cycle after rst falls; IDLE 1 cycle after busy falls; no gnt before that.
- Single requester: req[0]=1, pulse r_block with addr 0x0000_0400 → gnt=01 after 1 cycle; host_block_addr=0x400 and host_r_block pulse match; req_busy[1] stays 1.
- Contention: req=11 in IDLE after reset → gnt=01. Drop req[0] with busy=0 → gnt=10 two cycles later. Raise req[0] again and drop req[1] → gnt=01 (rotation).
- Drain: drop req[0] while host_busy=1 for 20 cycles → gnt=00 immediately; strobes from req[1] are ignored; gnt=10 only after busy falls +1 cycle.
- Watchdog (TIMEOUT_W=4): hold host_busy=1 in GRANT → timeout=1 after 15 cycles; gnt=0; host_rst high exactly 4 cycles; state_dbg shows INIT.
- Reset mid-GRANT: assert rst during a w_block → next edge gnt=0, host_rst=1, strobes 0; after release requester 0 wins a simultaneous 11 request.
